// File: rtl/csr_access_ctrl.sv
// Machine-mode CSR sequencer: runs Zicsr ops, trap entry and MRET on the single
// CSR read/write port, one CSR write per cycle, and returns rd / redirect results.
module csr_access_ctrl #(
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MTVEC_ADDR   = 12'h305,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
  parameter logic [11:0] MTVAL_ADDR   = 12'h343
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [2:0]  req_funct3,
  input  logic [11:0] req_csr_addr,
  input  logic [31:0] req_rs1_val,
  input  logic [4:0]  req_zimm,
  input  logic        req_src_zero,
  input  logic [31:0] req_cause,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_tval,
  output logic [11:0] csr_r_addr,
  input  logic [31:0] csr_r_val,
  output logic [11:0] csr_w_addr,
  output logic [31:0] csr_w_val,
  output logic        csr_w_enable,
  output logic        done_valid,
  output logic [31:0] done_rd_val,
  output logic        done_redirect,
  output logic [31:0] done_target,
  output logic        done_illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_CSR_OP, S_T_EPC, S_T_CAUSE, S_T_TVAL, S_T_STATUS, S_T_VEC,
    S_M_STATUS, S_M_EPC, S_DONE
  } state_t;

  state_t      state;
  logic [1:0]  kind_q;
  logic [2:0]  funct3_q;
  logic [11:0] addr_q;
  logic [31:0] rs1_q;
  logic [4:0]  zimm_q;
  logic        src_zero_q;
  logic [31:0] cause_q;
  logic [31:0] pc_q;
  logic [31:0] tval_q;

  logic [31:0] op_src;
  logic [31:0] op_new;
  logic        op_writes;
  logic        op_illegal;
  logic [31:0] vec_base;
  logic [31:0] vec_target;
  logic [31:0] trap_status;
  logic [31:0] mret_status;

  assign req_ready  = (state == S_IDLE) & ~reset;
  assign done_valid = (state == S_DONE);

  // RW always writes; RS/RC only when the source register/immediate is nonzero.
  always_comb begin
    op_src     = funct3_q[2] ? {27'b0, zimm_q} : rs1_q;
    op_writes  = (funct3_q[1:0] == 2'b01) | ~src_zero_q;
    op_illegal = (kind_q == 2'b11) | (funct3_q[1:0] == 2'b00) |
                 (op_writes & (addr_q[11:10] == 2'b11));
    case (funct3_q[1:0])
      2'b01:   op_new = op_src;
      2'b10:   op_new = csr_r_val | op_src;
      2'b11:   op_new = csr_r_val & ~op_src;
      default: op_new = csr_r_val;
    endcase
    vec_base   = {csr_r_val[31:2], 2'b00};
    vec_target = ((csr_r_val[1:0] == 2'b01) && cause_q[31]) ?
                 vec_base + {cause_q[29:0], 2'b00} : vec_base;
    trap_status        = csr_r_val;
    trap_status[7]     = csr_r_val[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;
    mret_status        = csr_r_val;
    mret_status[3]     = csr_r_val[7];
    mret_status[7]     = 1'b1;
    mret_status[12:11] = 2'b11;
  end

  // Port drive is decoded from state because write data depends on same-cycle read data.
  always_comb begin
    csr_r_addr   = 12'h000;
    csr_w_addr   = 12'h000;
    csr_w_val    = 32'h0;
    csr_w_enable = 1'b0;
    case (state)
      S_CSR_OP: begin
        csr_r_addr   = addr_q;
        csr_w_addr   = addr_q;
        csr_w_val    = op_new;
        csr_w_enable = op_writes & ~op_illegal;
      end
      S_T_EPC: begin
        csr_w_addr   = MEPC_ADDR;
        csr_w_val    = pc_q & ~32'h3;
        csr_w_enable = 1'b1;
      end
      S_T_CAUSE: begin
        csr_w_addr   = MCAUSE_ADDR;
        csr_w_val    = cause_q;
        csr_w_enable = 1'b1;
      end
      S_T_TVAL: begin
        csr_w_addr   = MTVAL_ADDR;
        csr_w_val    = tval_q;
        csr_w_enable = 1'b1;
      end
      S_T_STATUS: begin
        csr_r_addr   = MSTATUS_ADDR;
        csr_w_addr   = MSTATUS_ADDR;
        csr_w_val    = trap_status;
        csr_w_enable = 1'b1;
      end
      S_T_VEC:  csr_r_addr = MTVEC_ADDR;
      S_M_STATUS: begin
        csr_r_addr   = MSTATUS_ADDR;
        csr_w_addr   = MSTATUS_ADDR;
        csr_w_val    = mret_status;
        csr_w_enable = 1'b1;
      end
      S_M_EPC:  csr_r_addr = MEPC_ADDR;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      kind_q        <= 2'b00;
      funct3_q      <= 3'b000;
      addr_q        <= 12'h000;
      rs1_q         <= 32'h0;
      zimm_q        <= 5'h00;
      src_zero_q    <= 1'b0;
      cause_q       <= 32'h0;
      pc_q          <= 32'h0;
      tval_q        <= 32'h0;
      done_rd_val   <= 32'h0;
      done_redirect <= 1'b0;
      done_target   <= 32'h0;
      done_illegal  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            kind_q        <= req_kind;
            funct3_q      <= req_funct3;
            addr_q        <= req_csr_addr;
            rs1_q         <= req_rs1_val;
            zimm_q        <= req_zimm;
            src_zero_q    <= req_src_zero;
            cause_q       <= req_cause;
            pc_q          <= req_pc;
            tval_q        <= req_tval;
            done_redirect <= 1'b0;
            done_illegal  <= 1'b0;
            case (req_kind)
              2'b01:   state <= S_T_EPC;
              2'b10:   state <= S_M_STATUS;
              default: state <= S_CSR_OP;
            endcase
          end
        end
        S_CSR_OP: begin
          done_rd_val  <= op_illegal ? 32'h0 : csr_r_val;
          done_illegal <= op_illegal;
          state        <= S_DONE;
        end
        S_T_EPC:    state <= S_T_CAUSE;
        S_T_CAUSE:  state <= S_T_TVAL;
        S_T_TVAL:   state <= S_T_STATUS;
        S_T_STATUS: state <= S_T_VEC;
        S_T_VEC: begin
          done_target   <= vec_target;
          done_redirect <= 1'b1;
          state         <= S_DONE;
        end
        S_M_STATUS: state <= S_M_EPC;
        S_M_EPC: begin
          done_target   <= csr_r_val & ~32'h3;
          done_redirect <= 1'b1;
          state         <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Multi-cycle sequencer that owns the single read/write port pair of the machine-mode CSR register file.
- Executes Zicsr instructions (CSRRW/S/C and immediate forms), trap entry, and MRET as request/done transactions from the core pipeline.
- Breaks trap and MRET sequences into one-CSR-write-per-cycle steps and returns old CSR values and PC redirect targets.

Parameters:
MSTATUS_ADDR, 12'h300, mstatus address
MTVEC_ADDR, 12'h305, mtvec address
MEPC_ADDR, 12'h341, mepc address
MCAUSE_ADDR, 12'h342, mcause address
MTVAL_ADDR, 12'h343, mtval address

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller idle; accepts when req_valid & req_ready
req_kind  in  2  00 CSR op, 01 trap, 10 MRET, 11 reserved
req_funct3  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
req_csr_addr  in  12  target CSR
req_rs1_val  in  32  rs1 operand
req_zimm  in  5  immediate operand, zero-extended
req_src_zero  in  1  rs1 index or zimm is 0 (suppresses RS/RC write)
req_cause  in  32  trap cause
req_pc  in  32  faulting PC
req_tval  in  32  trap value
csr_r_addr  out  12  register file read address
csr_r_val  in  32  combinational read data (with same-cycle write bypass)
csr_w_addr  out  12  write address
csr_w_val  out  32  write data
csr_w_enable  out  1  write strobe
done_valid  out  1  one-cycle completion pulse
done_rd_val  out  32  old CSR value for rd
done_redirect  out  1  done_target valid
done_target  out  32  new PC
done_illegal  out  1  request raised an illegal-instruction condition

Behaviour:
- Reset: state=IDLE. done_* = 0, csr_w_enable = 0, csr addresses = 0, csr_w_val = 0. req_ready = 0 while reset is high.
- req_ready = (state==IDLE) & ~reset. On accept, all req_* fields are latched; inputs are ignored until the next IDLE.
- Read data: csr_r_val is sampled in the same cycle csr_r_addr is driven (combinational register file).
- CSR op state (one cycle): read addr, old = csr_r_val.
  - new = src for RW; old|src for RS; old&~src for RC. src = rs1_val, or {27'b0, zimm} for the I forms.
  - Write is suppressed for RS/RC/RSI/RCI when req_src_zero = 1.
  - Then go to DONE with rd_val = old.
- CSR op illegal cases: funct3 000/100; effective write to read-only CSR (addr[11:10]==2'b11); reserved kind. Result: no write, done_illegal = 1, rd_val = 0.
- Trap sequence, one state per cycle:
  - T_EPC: write mepc = pc & ~3.
  - T_CAUSE: write mcause = cause.
  - T_TVAL: write mtval = tval.
  - T_STATUS: read mstatus s; write s with MPIE[7] = s[3], MIE[3] = 0, MPP[12:11] = 2'b11.
  - T_VEC: read mtvec v; base = {v[31:2], 2'b00}; target = base + (cause[30:0] << 2) if v[1:0]==01 and cause[31], else base.
  - Go to DONE with redirect = 1.
- MRET sequence:
  - M_STATUS: read s; write s with MIE = s[7], MPIE = 1, MPP = 2'b11.
  - M_EPC: read mepc; target = mepc & ~3; redirect = 1.
  - Go to DONE.
- DONE: done_valid = 1 for exactly one cycle, then IDLE. done_* payload is registered and holds until the next DONE; done_redirect/done_illegal are cleared at each new accept.
- Latency, accept edge = cycle 0:
  - CSR op: write at cycle 1, done at cycle 2.
  - Trap: writes at cycles 1-4, done at cycle 6.
  - MRET: write at cycle 1, done at cycle 3.
- Throughput: one transaction in flight; a back-to-back request is accepted in the cycle after DONE.
- csr_w_enable is high only in write states; it never asserts in IDLE/DONE or on suppressed or illegal writes.
- Reset mid-sequence: return to IDLE immediately with no done pulse; CSR writes already performed remain.
- All address and arithmetic is modulo 2^32; vectored target wraps silently.

Test Plan:
- CSRRW 0x340 (holds 0x11111111), rs1 0xA5A5A5A5 -> write 0xA5A5A5A5 at cycle 1; done at cycle 2 with rd_val 0x11111111 and redirect 0.
- CSRRS mstatus (0xDEADBEEF), req_src_zero = 1 -> csr_w_enable never high; rd_val 0xDEADBEEF.
- CSRRCI 0x340 (0x000000FF), zimm 0x0F -> writes 0x000000F0.
- Trap with mstatus 0x00000008, mtvec 0x80000001, cause 0x80000007, pc 0x00001002, tval 0x55 -> result:
  - writes mepc 0x1000, mcause 0x80000007, mtval 0x55, mstatus 0x00001880;
  - done at cycle 6, target 0x8000001C.
- MRET with mstatus 0x00000080, mepc 0x00002001 -> mstatus 0x00001888; target 0x00002000; done at cycle 3.
- CSRRW 0xF11, then reserved kind 11, then reset asserted after T_EPC of a trap -> first two complete with done_illegal = 1 and no writes; the reset yields no done pulse, mepc stays written, req_ready returns 1.
